conv_frame_loader: RTL

Upstream feeder for the 7x7 / 3x3 convolution stage. It accepts a row-major 8-bit pixel stream and an 8-bit coefficient stream, both with valid/ready handshakes. It assembles complete 7x7 frames in a double buffer and holds a committed 3x3 filter. Whole frames and the filter are presented as flat buses, with a frame_valid/frame_ready handshake toward the convolution stage.

---
 rtl/conv_frame_loader_if.sv | 41 ++++
 rtl/conv_frame_loader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/conv_frame_loader_if.sv
// Pixel, coefficient and frame/filter signals of the convolution frame loader.
// The slave modport is the loader's view; the master modport is its surroundings.
interface conv_frame_loader_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IN_DIM = 7,
    parameter int unsigned K_DIM  = 3
);
    localparam int unsigned FRAME_W = IN_DIM * IN_DIM * DATA_W;
    localparam int unsigned FILT_W  = K_DIM * K_DIM * DATA_W;

    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic              pix_sof;

    logic              coef_valid;
    logic              coef_ready;
    logic [DATA_W-1:0] coef_data;

    logic               frame_valid;
    logic               frame_ready;
    logic [FRAME_W-1:0] frame_data;

    logic               filter_valid;
    logic [FILT_W-1:0]  filter_data;

    logic [7:0]         frame_cnt;
    logic               frame_err;

    modport slave (
        input  pix_valid, pix_data, pix_sof, coef_valid, coef_data, frame_ready,
        output pix_ready, coef_ready, frame_valid, frame_data,
               filter_valid, filter_data, frame_cnt, frame_err
    );

    modport master (
        output pix_valid, pix_data, pix_sof, coef_valid, coef_data, frame_ready,
        input  pix_ready, coef_ready, frame_valid, frame_data,
               filter_valid, filter_data, frame_cnt, frame_err
    );
endinterface

// File: rtl/conv_frame_loader.sv
// Assembles row-major pixel streams into whole frames (fill/hold double buffer)
// and commits complete coefficient sets as the 3x3 filter.
module conv_frame_loader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IN_DIM = 7,
    parameter int unsigned K_DIM  = 3
) (
    input  logic               clock,
    input  logic               reset,
    conv_frame_loader_if.slave bus
);
    localparam int unsigned NPIX       = IN_DIM * IN_DIM;
    localparam int unsigned NCOEF      = K_DIM * K_DIM;
    localparam int unsigned FRAME_W    = NPIX * DATA_W;
    localparam int unsigned FILT_W     = NCOEF * DATA_W;
    localparam int unsigned FILL_IDX_W = $clog2(NPIX);
    localparam int unsigned COEF_IDX_W = $clog2(NCOEF);

    localparam logic [FILL_IDX_W-1:0] LAST_PIX  = FILL_IDX_W'(NPIX - 1);
    localparam logic [COEF_IDX_W-1:0] LAST_COEF = COEF_IDX_W'(NCOEF - 1);

    typedef enum logic {
        S_FILL,
        S_FULL
    } state_e;

    state_e                 state_q, state_d;
    logic [FILL_IDX_W-1:0]  fill_idx_q, fill_idx_d;
    logic [COEF_IDX_W-1:0]  coef_idx_q, coef_idx_d;
    logic [FRAME_W-1:0]     fill_buf_q, fill_buf_d;
    logic [FRAME_W-1:0]     hold_buf_q, hold_buf_d;
    logic [FILT_W-1:0]      coef_shadow_q, coef_shadow_d;
    logic [FILT_W-1:0]      filter_q, filter_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   filter_valid_q, filter_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   pix_ready_q, pix_ready_d;
    logic                   coef_ready_q, coef_ready_d;
    logic [7:0]             frame_cnt_q, frame_cnt_d;

    logic pix_acc;
    logic coef_acc;
    logic xfer;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_FILL;
            fill_idx_q     <= '0;
            coef_idx_q     <= '0;
            fill_buf_q     <= '0;
            hold_buf_q     <= '0;
            coef_shadow_q  <= '0;
            filter_q       <= '0;
            frame_valid_q  <= 1'b0;
            filter_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            pix_ready_q    <= 1'b0;
            coef_ready_q   <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            fill_idx_q     <= fill_idx_d;
            coef_idx_q     <= coef_idx_d;
            fill_buf_q     <= fill_buf_d;
            hold_buf_q     <= hold_buf_d;
            coef_shadow_q  <= coef_shadow_d;
            filter_q       <= filter_d;
            frame_valid_q  <= frame_valid_d;
            filter_valid_q <= filter_valid_d;
            frame_err_q    <= frame_err_d;
            pix_ready_q    <= pix_ready_d;
            coef_ready_q   <= coef_ready_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        fill_idx_d     = fill_idx_q;
        coef_idx_d     = coef_idx_q;
        fill_buf_d     = fill_buf_q;
        hold_buf_d     = hold_buf_q;
        coef_shadow_d  = coef_shadow_q;
        filter_d       = filter_q;
        frame_valid_d  = frame_valid_q;
        filter_valid_d = filter_valid_q;
        frame_err_d    = frame_err_q;
        frame_cnt_d    = frame_cnt_q;

        pix_acc  = bus.pix_valid && pix_ready_q;
        coef_acc = bus.coef_valid && coef_ready_q;
        xfer     = (state_q == S_FULL) && (!frame_valid_q || bus.frame_ready);

        case (state_q)
            S_FILL: begin
                if (pix_acc) begin
                    // A mid-frame start-of-frame restarts assembly at pixel 0.
                    if (bus.pix_sof && (fill_idx_q != '0)) begin
                        fill_buf_d[DATA_W-1:0] = bus.pix_data;
                        fill_idx_d             = FILL_IDX_W'(1);
                        frame_err_d            = 1'b1;
                    end else begin
                        fill_buf_d[32'(fill_idx_q) * DATA_W +: DATA_W] = bus.pix_data;
                        if (fill_idx_q == LAST_PIX) begin
                            fill_idx_d = '0;
                            state_d    = S_FULL;
                        end else begin
                            fill_idx_d = fill_idx_q + FILL_IDX_W'(1);
                        end
                    end
                end
            end
            S_FULL: begin
                if (xfer) begin
                    hold_buf_d    = fill_buf_q;
                    frame_valid_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 8'd1;
                    state_d       = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase

        // A consume without a replacing transfer empties the hold buffer.
        if (frame_valid_q && bus.frame_ready && !xfer) begin
            frame_valid_d = 1'b0;
        end

        if (coef_acc) begin
            coef_shadow_d[32'(coef_idx_q) * DATA_W +: DATA_W] = bus.coef_data;
            if (coef_idx_q == LAST_COEF) begin
                filter_d       = coef_shadow_d;
                filter_valid_d = 1'b1;
                coef_idx_d     = '0;
            end else begin
                coef_idx_d = coef_idx_q + COEF_IDX_W'(1);
            end
        end

        pix_ready_d  = (state_d == S_FILL);
        coef_ready_d = 1'b1;
    end

    assign bus.pix_ready    = pix_ready_q;
    assign bus.coef_ready   = coef_ready_q;
    assign bus.frame_valid  = frame_valid_q;
    assign bus.frame_data   = hold_buf_q;
    assign bus.filter_valid = filter_valid_q;
    assign bus.filter_data  = filter_q;
    assign bus.frame_cnt    = frame_cnt_q;
    assign bus.frame_err    = frame_err_q;
endmodule
